// File: rtl/burst_mem_pkg.sv
// rtl/burst_mem_pkg.sv - shared types and width helpers for the burst memory responder
package burst_mem_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    WR_RESP  = 3'd4
  } mem_state_e;

  // Word-index width for a memory of num_words entries
  function automatic int idx_width(input int num_words);
    return $clog2(num_words);
  endfunction

  // Beat counter must hold the longer of the two burst lengths
  function automatic int beat_cnt_width(input int rd_len, input int wr_len);
    return $clog2(((rd_len > wr_len) ? rd_len : wr_len) + 1);
  endfunction

  // Latency counter width
  function automatic int lat_cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// rtl/burst_mem_array.sv - word storage with one synchronous write and one asynchronous read port
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 128,
  parameter int IDX_W      = idx_width(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately not reset so data survives a responder reset
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  // Commit one write beat per clock when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - fixed-latency burst read/write memory responder for L1 refill and writeback
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_WORDS       = 128,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8,
  parameter int ACCESS_LATENCY  = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  wr_done,
  output logic                  busy
);

  localparam int IDX_W  = idx_width(NUM_WORDS);
  localparam int BEAT_W = beat_cnt_width(READ_BURST_LEN, WRITE_BURST_LEN);
  localparam int LAT_W  = lat_cnt_width(ACCESS_LATENCY);

  localparam logic [BEAT_W-1:0] LAST_RD  = BEAT_W'(READ_BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] LAST_WR  = BEAT_W'(WRITE_BURST_LEN - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT = LAT_W'(ACCESS_LATENCY - 1);

  mem_state_e            state;
  logic [IDX_W-1:0]      idx;
  logic [BEAT_W-1:0]     beat;
  logic [LAT_W-1:0]      lat_cnt;

  logic [IDX_W-1:0]      req_idx;
  logic [IDX_W-1:0]      idx_next;
  logic [IDX_W-1:0]      mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  unused_addr_bits;

  // Byte offset and bits above the memory depth do not select a word
  assign req_idx          = req_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[1:0]};

  // Index arithmetic wraps naturally at NUM_WORDS since the depth is a power of 2
  assign idx_next = idx + IDX_W'(1);

  // Look one word ahead during a read burst so the next beat is ready at the handshake edge
  assign mem_raddr = (state == RD_BURST) ? idx_next : idx;
  assign mem_we    = wdata_ready & wdata_valid;

  burst_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (sys_clk),
    .we    (mem_we),
    .waddr (idx),
    .wdata (wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Request/burst FSM with registered handshake outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      wr_done     <= 1'b0;
      rdata       <= '0;
      idx         <= '0;
      beat        <= '0;
      lat_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx       <= req_idx;
            beat      <= '0;
            lat_cnt   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_write) begin
              state       <= WR_BURST;
              wdata_ready <= 1'b1;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == LAST_LAT) begin
            state       <= RD_BURST;
            rdata_valid <= 1'b1;
            rdata       <= mem_rdata;
            rdata_last  <= (READ_BURST_LEN == 1);
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        RD_BURST: begin
          if (rdata_ready) begin
            if (beat == LAST_RD) begin
              state       <= IDLE;
              rdata_valid <= 1'b0;
              rdata_last  <= 1'b0;
              req_ready   <= 1'b1;
              busy        <= 1'b0;
            end else begin
              beat       <= beat + BEAT_W'(1);
              idx        <= idx_next;
              rdata      <= mem_rdata;
              rdata_last <= ((beat + BEAT_W'(1)) == LAST_RD);
            end
          end
        end
        WR_BURST: begin
          if (wdata_valid) begin
            idx <= idx_next;
            if (beat == LAST_WR) begin
              state       <= WR_RESP;
              wdata_ready <= 1'b0;
              lat_cnt     <= '0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        WR_RESP: begin
          if (wr_done) begin
            wr_done   <= 1'b0;
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (lat_cnt == LAST_LAT) begin
            wr_done <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          req_ready   <= 1'b1;
          busy        <= 1'b0;
          wdata_ready <= 1'b0;
          rdata_valid <= 1'b0;
          rdata_last  <= 1'b0;
          wr_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
